// File: rtl/div_unit_pkg.sv
// Shared constants and types for the multi-cycle radix-2 restoring divider.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  // Result-ready levels
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  // Divider FSM state encodings (2 bits)
  localparam logic [1:0] DIV_FREE   = 2'b00;
  localparam logic [1:0] DIV_BYZERO = 2'b01;
  localparam logic [1:0] DIV_ON     = 2'b10;
  localparam logic [1:0] DIV_END    = 2'b11;

  // Decode control codes that select signed_div (DIV vs DIVU)
  localparam logic [7:0] DIV_CONTROL  = 8'b0001_1010;
  localparam logic [7:0] DIVU_CONTROL = 8'b0001_1011;

  // Operand signs captured at accept; both stay 0 for DIVU so the fix-up is a no-op
  typedef struct packed {
    logic neg_dividend;
    logic neg_divisor;
  } div_sign_t;

  // Magnitude of a two's-complement value when en=1, raw value otherwise.
  // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
  function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] v,
                                                   input logic                 en);
    return (en && v[DIV_WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract divisor.
import div_unit_pkg::*;

module div_step #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quo_n
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // 33-bit trial subtract; diff[WIDTH] set means the shifted remainder was below the divisor
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    rem_n   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_n   = {quo[WIDTH-2:0], ~diff[WIDTH]};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit radix-2 restoring divider (DIV/DIVU), responder side of the
// div_start/div_ready handshake. Dividend bits are shifted out of the quotient
// register as quotient bits shift in.
import div_unit_pkg::*;

module div_unit #(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, divisor;
  logic [WIDTH-1:0] rem_n, quo_n;
  logic [WIDTH-1:0] q_fix, r_fix;
  div_sign_t        sgn;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (divisor),
    .rem_n   (rem_n),
    .quo_n   (quo_n)
  );

  // Sign fix-up on the final step's outputs, so result is already registered
  // when END presents ready (one cycle saved versus fixing up inside END).
  always_comb begin
    q_fix = (sgn.neg_dividend ^ sgn.neg_divisor) ? (~quo_n + 1'b1) : quo_n;
    r_fix = sgn.neg_dividend ? (~rem_n + 1'b1) : rem_n;
  end

  // Divider FSM, iteration counter and result/ready registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= DIV_FREE;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      sgn     <= '0;
      result  <= '0;
      ready   <= DIV_RESULT_NOT_READY;
    end else begin
      ready <= DIV_RESULT_NOT_READY;
      case (state)
        DIV_FREE: begin
          if (start && !annul) begin
            sgn.neg_dividend <= signed_div & opdata1[WIDTH-1];
            sgn.neg_divisor  <= signed_div & opdata2[WIDTH-1];
            divisor          <= abs_val(opdata2, signed_div);
            quo              <= abs_val(opdata1, signed_div);
            rem              <= '0;
            cnt              <= '0;
            if (opdata2 == '0) begin
              result <= {opdata1, {WIDTH{1'b1}}};
              ready  <= DIV_RESULT_READY;
              state  <= DIV_BYZERO;
            end else begin
              state  <= DIV_ON;
            end
          end
        end
        DIV_ON: begin
          if (annul || !start) begin
            // abandoned: result keeps its previous value
            state <= DIV_FREE;
          end else begin
            rem <= rem_n;
            quo <= quo_n;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH-1)) begin
              result <= {r_fix, q_fix};
              ready  <= DIV_RESULT_READY;
              state  <= DIV_END;
            end
          end
        end
        // ready is committed in these states regardless of annul
        DIV_END, DIV_BYZERO: state <= DIV_FREE;
        default:             state <= DIV_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized divides
// checked against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] last_res;

  always #5 clk = ~clk;

  div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .result     (result),
    .ready      (ready)
  );

  // Reference: {remainder, quotient} from plain integer arithmetic
  function automatic logic [63:0] model(input bit sd, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!sd) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa - q * sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one divide, hold start until ready, check latency/result, then one FREE cycle
  task automatic run_div(input bit sd, input logic [31:0] a, input logic [31:0] b, input string tag);
    int          n;
    bit          seen;
    logic [63:0] exp;
    exp        = model(sd, a, b);
    signed_div = sd;
    opdata1    = a;
    opdata2    = b;
    annul      = 1'b0;
    start      = 1'b1;
    n          = 0;
    seen       = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (ready) seen = 1'b1;
      else if (n == 1) begin
        // operands must only matter on the accept cycle
        opdata1 = $urandom;
        opdata2 = $urandom;
      end
    end
    start = 1'b0;
    check({tag, ".lat"}, 64'(n), 64'((b == 32'd0) ? 1 : 33));
    check({tag, ".res"}, result, exp);
    last_res = exp;
    tick();
    check({tag, ".rdy_after"}, 64'(ready), 64'd0);
  endtask

  // Start a divide, abandon it after 10 cycles via annul (mode=1) or dropping start (mode=0)
  task automatic run_abort(input bit use_annul, input string tag);
    int hits;
    signed_div = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd7;
    annul      = 1'b0;
    start      = 1'b1;
    hits       = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ready) hits++;
    end
    if (use_annul) annul = 1'b1;
    else           start = 1'b0;
    tick();
    if (ready) hits++;
    annul = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ready) hits++;
    end
    check({tag, ".no_ready"}, 64'(hits), 64'd0);
    check({tag, ".res_kept"}, result, last_res);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    signed_div = 1'b0;
    annul      = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    last_res   = '0;
    #12;
    check("reset.ready", 64'(ready), 64'd0);
    check("reset.result", result, 64'd0);
    rst = 1'b0;
    tick();

    // 1: basic unsigned, latency
    run_div(1'b0, 32'd100, 32'd7, "t1_divu");
    check("t1.const", result, {32'd2, 32'd14});

    // 2: sign handling
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, "t2_neg_dividend");
    check("t2a.const", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, "t2_neg_divisor");
    check("t2b.const", result, {32'd1, 32'hFFFF_FFFD});
    run_div(1'b0, 32'hFFFF_FFF9, 32'd2, "t2_divu_big");
    check("t2c.const", result, {32'd1, 32'h7FFF_FFFC});

    // 3: zero divisor
    run_div(1'b1, 32'd5, 32'd0, "t3_byzero");
    check("t3.const", result, {32'd5, 32'hFFFF_FFFF});

    // 4: abandon then a clean divide
    run_abort(1'b1, "t4_annul");
    run_abort(1'b0, "t4_drop_start");
    run_div(1'b0, 32'd9, 32'd3, "t4_after");
    check("t4.const", result, {32'd0, 32'd3});

    // 5: back-to-back, including signed overflow
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "t5_overflow");
    check("t5.const", result, {32'd0, 32'h8000_0000});
    run_div(1'b1, 32'h8000_0000, 32'd1, "t5_min_by_one");

    // randomized mix, all back-to-back
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      bit          sd;
      a  = $urandom;
      sd = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = $urandom_range(1, 15);
        2:       b = -$urandom_range(1, 15);
        3:       b = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> 16);
        default: begin a = a >> $urandom_range(0, 31); b = $urandom >> $urandom_range(0, 31); end
      endcase
      run_div(sd, a, b, $sformatf("rand%0d", i));
    end

    // 6: async reset between clock edges mid-operation
    signed_div = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd3;
    start      = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    #3;
    rst   = 1'b1;
    start = 1'b0;
    #1;
    check("t6.ready", 64'(ready), 64'd0);
    check("t6.result", result, 64'd0);
    #1;
    rst = 1'b0;
    tick();
    run_div(1'b0, 32'd1, 32'd1, "t6_after");
    check("t6.const", result, {32'd0, 32'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
